// File: rtl/ttc_pkg.sv
// rtl/ttc_pkg.sv - shared constants, resync FSM state type and saturating increment for the TTC generator
//
// Purpose : common definitions imported by ttc_generator and ttc_l1a_gen.
// Contents: MXBXN (BXN width), LHC_CYCLE (BXN wrap), MXCNT (L1A counter width),
//           resync_state_t (IDLE/ARMED/SEND/HOLD), sat_inc (saturating +1).

package ttc_pkg;

  localparam int MXBXN     = 12;
  localparam int LHC_CYCLE = 3564;
  localparam int MXCNT     = 32;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARMED,
    ST_SEND,
    ST_HOLD
  } resync_state_t;

  function automatic logic [MXCNT-1:0] sat_inc(input logic [MXCNT-1:0] v);
    return (v == '1) ? v : v + MXCNT'(1);
  endfunction

endpackage

// File: rtl/ttc_l1a_gen.sv
// rtl/ttc_l1a_gen.sv - L1A arbitration: periodic source, pending flag, gap timer, issue/drop counters
//
// Purpose : turns L1A requests into ttc_l1a strobes that never land on a bx0 or
//           resync cycle, respect the minimum L1A spacing and the post-resync holdoff.
// Config  : TTC_GEN_L1A_PERIODIC_EN adds the periodic L1A source driven by l1a_period.
// Ports   : clock, reset        - clock, synchronous active-high reset
//           enable              - generator running
//           l1a_req             - external L1A request
//           l1a_period          - periodic interval (0 = off), used only with the macro
//           bx0_next            - the cycle being launched carries ttc_bx0
//           resync_next         - the cycle being launched carries ttc_resync
//           hold, hold_next     - resync FSM is in HOLD now / in the cycle being launched
//           ttc_l1a             - registered L1A strobe
//           l1a_count           - saturating count of issued L1As
//           l1a_drop_count      - saturating count of dropped requests

module ttc_l1a_gen
  import ttc_pkg::*;
#(
  parameter int MIN_L1A_GAP = 3
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             l1a_req,
  input  logic [15:0]      l1a_period,
  input  logic             bx0_next,
  input  logic             resync_next,
  input  logic             hold,
  input  logic             hold_next,
  output logic             ttc_l1a,
  output logic [MXCNT-1:0] l1a_count,
  output logic [MXCNT-1:0] l1a_drop_count
);

  localparam int GAP_W = (MIN_L1A_GAP > 2) ? $clog2(MIN_L1A_GAP) : 1;
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(MIN_L1A_GAP - 1);

  logic [GAP_W-1:0] gap_cnt;
  logic             pending;
  logic             tick;
  logic             req;
  logic             gap_ok;
  logic             slot_free;
  logic             drop;
  logic             issue;
  logic             park;

`ifdef TTC_GEN_L1A_PERIODIC_EN
  logic [15:0] per_cnt;
  logic        per_on;

  assign per_on = enable && (l1a_period != 16'd0);
  assign tick   = per_on && (per_cnt == l1a_period - 16'd1);

  // Restarting on resync keeps the periodic phase aligned to the resync point.
  always_ff @(posedge clock) begin
    if (reset || !per_on || resync_next || tick) begin
      per_cnt <= 16'd0;
    end else begin
      per_cnt <= per_cnt + 16'd1;
    end
  end
`else
  logic unused_period;
  assign unused_period = ^l1a_period;
  assign tick          = 1'b0;
`endif

  // A coincident external request and periodic tick are one request.
  assign req    = l1a_req | tick;
  // Gap timer is loaded when an L1A launches; zero means spacing satisfied.
  assign gap_ok = (gap_cnt == '0);
  // A launch slot must not carry bx0/resync nor fall inside the holdoff.
  assign slot_free = enable && !bx0_next && !resync_next && !hold_next && gap_ok;
  assign drop  = req && (!enable || pending || hold || !gap_ok);
  assign issue = slot_free && (pending || (req && !drop));
  assign park  = req && !drop && !slot_free;

  always_ff @(posedge clock) begin
    if (reset) begin
      ttc_l1a        <= 1'b0;
      pending        <= 1'b0;
      gap_cnt        <= '0;
      l1a_count      <= '0;
      l1a_drop_count <= '0;
    end else begin
      ttc_l1a <= issue;

      if (!enable || issue) begin
        pending <= 1'b0;
      end else if (park) begin
        pending <= 1'b1;
      end

      if (issue) begin
        gap_cnt <= GAP_LOAD;
      end else if (!gap_ok) begin
        gap_cnt <= gap_cnt - GAP_W'(1);
      end

      // Counters clear on the edge that launches ttc_resync, so they read 0 in that cycle.
      if (resync_next) begin
        l1a_count      <= '0;
        l1a_drop_count <= '0;
      end else begin
        if (issue) l1a_count      <= sat_inc(l1a_count);
        if (drop)  l1a_drop_count <= sat_inc(l1a_drop_count);
      end
    end
  end

endmodule

// File: rtl/ttc_generator.sv
// rtl/ttc_generator.sv - TTC generator top: BXN counter, BC0 strobe, resync FSM, L1A generator instance
//
// Purpose : local BX counter with BC0, a resync sequencer (IDLE/ARMED/SEND/HOLD)
//           and L1A generation through ttc_l1a_gen.
// Config  : TTC_GEN_L1A_PERIODIC_EN enables the periodic L1A source (l1a_period).
// Ports   : clock, reset        - BX clock, synchronous active-high reset
//           enable              - run; 0 holds bxn_counter at 0 and emits nothing
//           resync_req          - request one resync
//           l1a_req             - request one L1A
//           l1a_period          - periodic L1A interval in cycles, 0 = off
//           bxn_counter         - local BXN
//           ttc_bx0, ttc_resync, ttc_l1a - registered, mutually exclusive strobes
//           resync_busy         - resync FSM not IDLE
//           l1a_count, l1a_drop_count    - saturating L1A issue/drop counters

module ttc_generator
  import ttc_pkg::*;
#(
  parameter int RESYNC_BX   = 100,
  parameter int HOLDOFF     = 16,
  parameter int MIN_L1A_GAP = 3
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             resync_req,
  input  logic             l1a_req,
  input  logic [15:0]      l1a_period,
  output logic [MXBXN-1:0] bxn_counter,
  output logic             ttc_bx0,
  output logic             ttc_resync,
  output logic             ttc_l1a,
  output logic             resync_busy,
  output logic [MXCNT-1:0] l1a_count,
  output logic [MXCNT-1:0] l1a_drop_count
);

  localparam int HC_W = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
  localparam logic [MXBXN-1:0] BXN_LAST   = MXBXN'(LHC_CYCLE - 1);
  localparam logic [MXBXN-1:0] BXN_RESYNC = MXBXN'(RESYNC_BX);
  localparam logic [HC_W-1:0]  HOLD_LAST  = HC_W'(HOLDOFF - 1);

  resync_state_t    state;
  resync_state_t    state_next;
  logic [HC_W-1:0]  hold_cnt;
  logic [HC_W-1:0]  hold_cnt_next;
  logic             running;
  logic [MXBXN-1:0] bxn_next;
  logic             bx0_next;
  logic             resync_next;

  // The first enabled cycle shows BXN 0 with bx0; counting starts from there.
  always_comb begin
    bxn_next = '0;
    if (enable && running) begin
      bxn_next = (bxn_counter == BXN_LAST) ? '0 : bxn_counter + MXBXN'(1);
    end
  end

  assign bx0_next = enable && (bxn_next == '0);

  // Transitions look at bxn_next so that ttc_resync is visible in the cycle
  // where bxn_counter equals RESYNC_BX.
  always_comb begin
    state_next    = state;
    hold_cnt_next = '0;
    case (state)
      ST_IDLE:  if (resync_req) state_next = ST_ARMED;
      ST_ARMED: if (bxn_next == BXN_RESYNC && !bx0_next) state_next = ST_SEND;
      ST_SEND:  state_next = ST_HOLD;
      ST_HOLD: begin
        if (hold_cnt == HOLD_LAST) state_next = ST_IDLE;
        else hold_cnt_next = hold_cnt + HC_W'(1);
      end
      default:  state_next = ST_IDLE;
    endcase
    if (!enable) begin
      state_next    = ST_IDLE;
      hold_cnt_next = '0;
    end
  end

  assign resync_next = (state_next == ST_SEND);
  assign resync_busy = (state != ST_IDLE);

  always_ff @(posedge clock) begin
    if (reset) begin
      running     <= 1'b0;
      bxn_counter <= '0;
      state       <= ST_IDLE;
      hold_cnt    <= '0;
      ttc_bx0     <= 1'b0;
      ttc_resync  <= 1'b0;
    end else begin
      running     <= enable;
      bxn_counter <= bxn_next;
      state       <= state_next;
      hold_cnt    <= hold_cnt_next;
      ttc_bx0     <= bx0_next;
      ttc_resync  <= resync_next;
    end
  end

  ttc_l1a_gen #(
    .MIN_L1A_GAP (MIN_L1A_GAP)
  ) u_l1a_gen (
    .clock          (clock),
    .reset          (reset),
    .enable         (enable),
    .l1a_req        (l1a_req),
    .l1a_period     (l1a_period),
    .bx0_next       (bx0_next),
    .resync_next    (resync_next),
    .hold           (state == ST_HOLD),
    .hold_next      (state_next == ST_HOLD),
    .ttc_l1a        (ttc_l1a),
    .l1a_count      (l1a_count),
    .l1a_drop_count (l1a_drop_count)
  );

endmodule

// File: tb/tb_ttc_generator.sv
// tb/tb_ttc_generator.sv - self-checking bench for ttc_generator (L1A vector table plus scoreboards)

module tb_ttc_generator;
  import ttc_pkg::*;

  logic             clock = 1'b0;
  logic             reset;
  logic             enable;
  logic             resync_req;
  logic             l1a_req;
  logic [15:0]      l1a_period;
  logic [MXBXN-1:0] bxn_counter;
  logic             ttc_bx0;
  logic             ttc_resync;
  logic             ttc_l1a;
  logic             resync_busy;
  logic [MXCNT-1:0] l1a_count;
  logic [MXCNT-1:0] l1a_drop_count;

  always #5 clock = ~clock;

  ttc_generator dut (
    .clock          (clock),
    .reset          (reset),
    .enable         (enable),
    .resync_req     (resync_req),
    .l1a_req        (l1a_req),
    .l1a_period     (l1a_period),
    .bxn_counter    (bxn_counter),
    .ttc_bx0        (ttc_bx0),
    .ttc_resync     (ttc_resync),
    .ttc_l1a        (ttc_l1a),
    .resync_busy    (resync_busy),
    .l1a_count      (l1a_count),
    .l1a_drop_count (l1a_drop_count)
  );

  typedef struct {
    int start_bx;
    int nreq;
    int exp_a;
    int exp_b;
    int exp_drop;
  } l1a_vec_t;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int l1a_q[$];
  int res_q[$];
  int bx0_q[$];
  bit bx0_mon = 1'b0;
  bit l1a_mon = 1'b1;
  int excl_viol = 0;
  int l1a_seen = 0;
  int l1a_on_bx0 = 0;
  int res_seen = 0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
    cyc++;
    if (int'(ttc_bx0) + int'(ttc_resync) + int'(ttc_l1a) > 1) excl_viol++;
    if (ttc_l1a) begin
      l1a_seen++;
      if (ttc_bx0) l1a_on_bx0++;
      if (l1a_mon) begin
        if (l1a_q.size() == 0) check("l1a_unexpected_cycle", cyc, -1);
        else check("l1a_cycle", cyc, l1a_q.pop_front());
      end
    end
    if (ttc_resync) begin
      res_seen++;
      if (res_q.size() == 0) check("resync_unexpected_bxn", bxn_counter, -1);
      else check("resync_bxn", bxn_counter, res_q.pop_front());
    end
    if (bx0_mon && ttc_bx0) begin
      if (bx0_q.size() == 0) check("bx0_unexpected_cycle", cyc, -1);
      else check("bx0_cycle", cyc, bx0_q.pop_front());
    end
  endtask

  task automatic wait_bxn(input int b);
    int n = 0;
    while (int'(bxn_counter) != b && n < 4000) begin
      step();
      n++;
    end
    if (int'(bxn_counter) != b) check("wait_bxn_timeout", bxn_counter, b);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_bxn"}, bxn_counter, 0);
    check({tag, "_bx0"}, ttc_bx0, 0);
    check({tag, "_resync"}, ttc_resync, 0);
    check({tag, "_l1a"}, ttc_l1a, 0);
    check({tag, "_busy"}, resync_busy, 0);
    check({tag, "_l1a_count"}, l1a_count, 0);
    check({tag, "_drop_count"}, l1a_drop_count, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: run did not complete, cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    l1a_vec_t vecs[7];
    int exp_cnt = 0;
    int exp_drop = 0;
    int bxn_err = 0;
    int bxn_at_last = -1;
    int bxn_at_wrap = -1;
    int base;

    vecs[0] = '{200,  1, 201,  -1, 0};
    vecs[1] = '{300,  2, 301,  -1, 1};
    vecs[2] = '{400,  3, 401,  -1, 2};
    vecs[3] = '{500,  4, 501, 504, 2};
    vecs[4] = '{3562, 2, 3563, -1, 1};
    vecs[5] = '{3563, 1, 1,    -1, 0};
    vecs[6] = '{3563, 2, 1,    -1, 1};

    reset      = 1'b1;
    enable     = 1'b0;
    resync_req = 1'b0;
    l1a_req    = 1'b0;
    l1a_period = 16'd0;
    repeat (3) step();
    check_reset_outputs("reset");
    reset = 1'b0;
    step();

    // BXN counting and BC0 period over 10000 enabled cycles.
    bx0_q.push_back(cyc + 1);
    bx0_q.push_back(cyc + 1 + LHC_CYCLE);
    bx0_q.push_back(cyc + 1 + 2 * LHC_CYCLE);
    bx0_mon = 1'b1;
    enable  = 1'b1;
    for (int k = 0; k < 10000; k++) begin
      step();
      if (int'(bxn_counter) != k % LHC_CYCLE) bxn_err++;
      if (k == LHC_CYCLE - 1) bxn_at_last = int'(bxn_counter);
      if (k == LHC_CYCLE) bxn_at_wrap = int'(bxn_counter);
    end
    bx0_mon = 1'b0;
    check("bxn_sequence_errors", bxn_err, 0);
    check("bxn_before_wrap", bxn_at_last, LHC_CYCLE - 1);
    check("bxn_after_wrap", bxn_at_wrap, 0);
    check("bx0_pending_expectations", bx0_q.size(), 0);

    // L1A vector table: request position/length against expected strobe BXNs and drops.
    for (int i = 0; i < 7; i++) begin
      wait_bxn(vecs[i].start_bx);
      base = cyc;
      l1a_q.push_back(base + ((vecs[i].exp_a - vecs[i].start_bx + LHC_CYCLE) % LHC_CYCLE));
      exp_cnt++;
      if (vecs[i].exp_b >= 0) begin
        l1a_q.push_back(base + ((vecs[i].exp_b - vecs[i].start_bx + LHC_CYCLE) % LHC_CYCLE));
        exp_cnt++;
      end
      exp_drop += vecs[i].exp_drop;
      l1a_req = 1'b1;
      repeat (vecs[i].nreq) step();
      l1a_req = 1'b0;
      repeat (8) step();
      check($sformatf("vec%0d_l1a_count", i), l1a_count, exp_cnt);
      check($sformatf("vec%0d_drop_count", i), l1a_drop_count, exp_drop);
      check($sformatf("vec%0d_l1a_outstanding", i), l1a_q.size(), 0);
    end

    // Resync: request at BXN 50, second request at 60 ignored, strobe at 100, busy through 116.
    wait_bxn(50);
    resync_req = 1'b1;
    step();
    resync_req = 1'b0;
    res_q.push_back(100);
    check("resync_armed_busy", resync_busy, 1);
    wait_bxn(60);
    resync_req = 1'b1;
    step();
    resync_req = 1'b0;
    wait_bxn(100);
    check("resync_strobe_at_100", ttc_resync, 1);
    check("resync_clears_l1a_count", l1a_count, 0);
    check("resync_clears_drop_count", l1a_drop_count, 0);
    wait_bxn(105);
    l1a_req = 1'b1;
    step();
    l1a_req = 1'b0;
    wait_bxn(116);
    check("hold_busy_last", resync_busy, 1);
    step();
    check("hold_done_idle", resync_busy, 0);
    check("hold_drop_count", l1a_drop_count, 1);
    check("hold_no_l1a", l1a_count, 0);
    repeat (LHC_CYCLE) step();
    check("single_resync_pulse", res_seen, 1);

    // enable=0 returns the FSM to IDLE, zeroes BXN and drops requests.
    wait_bxn(20);
    resync_req = 1'b1;
    step();
    resync_req = 1'b0;
    check("disable_pre_busy", resync_busy, 1);
    enable = 1'b0;
    step();
    check("disable_busy_cleared", resync_busy, 0);
    check("disable_bxn_zero", bxn_counter, 0);
    l1a_req = 1'b1;
    step();
    l1a_req = 1'b0;
    step();
    check("disable_drop_count", l1a_drop_count, 2);
    check("disable_no_l1a", l1a_count, 0);

    // Reset while ARMED aborts the resync.
    enable = 1'b1;
    step();
    wait_bxn(10);
    resync_req = 1'b1;
    step();
    resync_req = 1'b0;
    check("armed_before_reset", resync_busy, 1);
    reset = 1'b1;
    step();
    check_reset_outputs("reset_in_armed");
    reset = 1'b0;
    repeat (200) step();
    check("no_resync_after_reset", res_seen, 1);

    // Periodic L1A source over one orbit.
    reset  = 1'b1;
    enable = 1'b0;
    step();
    reset      = 1'b0;
    l1a_period = 16'd1000;
    l1a_mon    = 1'b0;
    l1a_seen   = 0;
    l1a_on_bx0 = 0;
    enable     = 1'b1;
    repeat (LHC_CYCLE) step();
`ifdef TTC_GEN_L1A_PERIODIC_EN
    check("periodic_count_in_range", (l1a_seen >= 3 && l1a_seen <= 4) ? 1 : 0, 1);
    check("periodic_count_reg", l1a_count, l1a_seen);
    check("periodic_l1a_on_bx0", l1a_on_bx0, 0);
`else
    check("periodic_disabled_seen", l1a_seen, 0);
    check("periodic_disabled_count", l1a_count, 0);
`endif

    check("strobe_exclusive_violations", excl_viol, 0);
    check("l1a_outstanding_final", l1a_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ttc_generator.md
TTC_GENERATOR -- requirements
Module: ttc_generator

Interface
REQ-001 Parameters SHALL be MXBXN=12 (BXN width); LHC_CYCLE=3564 (BXN wrap, max count+1); MXCNT=32 (counter width); RESYNC_BX=100 (BXN at which a resync is emitted); HOLDOFF=16 (post-resync L1A suppression cycles); MIN_L1A_GAP=3 (minimum cycles between L1As).
REQ-002 Single clock `clock`; reset `reset` SHALL be synchronous, active-high.
REQ-003 Ports (name, direction, width, meaning):
- clock  in  1  BX clock.
- reset  in  1  sync active-high reset.
- enable  in  1  generator run; 0 holds counter at 0 and emits nothing.
- resync_req  in  1  request one resync; sampled each cycle.
- l1a_req  in  1  request one L1A.
- l1a_period  in  16  periodic L1A interval in cycles; 0 = off.
- bxn_counter  out  MXBXN  local BXN.
- ttc_bx0  out  1  BC0 strobe.
- ttc_resync  out  1  resync strobe.
- ttc_l1a  out  1  L1A strobe.
- resync_busy  out  1  resync FSM not IDLE.
- l1a_count  out  MXCNT  L1As issued.
- l1a_drop_count  out  MXCNT  L1A requests dropped.

Function
REQ-004 bxn_counter SHALL increment by 1 per cycle while enable=1, wrap LHC_CYCLE-1 -> 0, and be forced to 0 while enable=0.
REQ-005 ttc_bx0 SHALL be a registered one-cycle strobe high exactly in cycles where bxn_counter==0 and enable=1; period exactly LHC_CYCLE cycles.
REQ-006 Resync FSM states SHALL be IDLE, ARMED, SEND, HOLD: IDLE->ARMED on resync_req&enable; ARMED->SEND when bxn_counter==RESYNC_BX; SEND asserts ttc_resync for one cycle then ->HOLD; HOLD counts HOLDOFF cycles then ->IDLE.
REQ-007 resync_req while not IDLE SHALL be ignored; enable=0 SHALL return the FSM to IDLE in the next cycle.
REQ-008 ttc_bx0, ttc_resync, ttc_l1a SHALL be mutually exclusive in any cycle; priority bx0 > resync > l1a.
REQ-009 An L1A request (l1a_req or periodic tick) colliding with bx0/resync SHALL be held in a one-deep pending flag and issued on the next legal cycle.
REQ-010 A request arriving while pending is set, during HOLD, within MIN_L1A_GAP cycles of the previous ttc_l1a, or with enable=0, SHALL be dropped and increment l1a_drop_count.
REQ-011 Simultaneous l1a_req and periodic tick SHALL count as one request.
REQ-012 l1a_count SHALL increment on each ttc_l1a; both counters SHALL saturate at all-ones and clear on reset or ttc_resync.
REQ-013 All strobes SHALL be registered outputs; latency from l1a_req to ttc_l1a, when unblocked, SHALL be one cycle.

Reset
REQ-014 On reset: bxn_counter=0, all strobes 0, FSM IDLE, resync_busy=0, pending cleared, gap timer expired, periodic timer 0, both counters 0.
REQ-015 Reset mid-resync SHALL abort without emitting ttc_resync.

Configuration
REQ-016 Macro TTC_GEN_L1A_PERIODIC_EN defined: periodic L1A source active, tick every l1a_period cycles when l1a_period!=0 and enable=1, timer reloaded on ttc_resync. Undefined: l1a_period ignored, only l1a_req generates L1As, periodic logic absent.

Structure
REQ-017 Package ttc_pkg SHALL hold MXBXN, LHC_CYCLE, MXCNT and the resync FSM state enum.
REQ-018 Sub-module ttc_l1a_gen SHALL contain periodic timer, pending flag, gap timer and L1A counters; top holds BXN counter and resync FSM.

Verification
REQ-019 enable=1 for 10000 cycles -> ttc_bx0 at cycles 0, 3564, 7128; bxn_counter 3563->0.
REQ-020 resync_req at bxn=50 -> ttc_resync at bxn=100, resync_busy 1 until 16 cycles later; second req at bxn=60 ignored.
REQ-021 l1a_req when bxn_counter==3563 -> no L1A at bxn=0 (bx0), ttc_l1a at bxn=1, drop count 0.
REQ-022 l1a_req on two consecutive cycles with MIN_L1A_GAP=3 -> one ttc_l1a, l1a_drop_count=1.
REQ-023 TTC_GEN_L1A_PERIODIC_EN, l1a_period=1000 for 3564 cycles -> l1a_count=3 or 4 with no L1A coincident with bx0; undefined -> l1a_count=0.
REQ-024 reset asserted in ARMED -> no ttc_resync, all outputs at reset values next cycle.
